// File: rtl/clk_pkg.sv
// Shared types and defaults for the programmable clock divider.
// Holds the counter type, the controller state enum and the default half-period.
package clk_pkg;

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned DEF_HALF = 5000;

  typedef logic [CNT_W-1:0] counter_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } div_state_t;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and toggle flop of the divider.
// Ports: clk, rst (async, active-high), en, clr, half (active half-period),
//        o_clk (divided clock), wrap (counter at half-1), wrap_rise (wrap with o_clk low).
module clk_div_core
  import clk_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] half,
  output logic         o_clk,
  output logic         wrap,
  output logic         wrap_rise
);

  logic [W-1:0] cnt;

  // half is never 0, so half-1 cannot wrap around.
  assign wrap      = (cnt == half - W'(1));
  assign wrap_rise = wrap && !o_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      o_clk <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      o_clk <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt   <= '0;
        o_clk <= ~o_clk;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller: start/stop sequencing, config handshake, boundary-safe apply.
// Ports: i_clk_FPGA, i_reset, i_start, i_stop, i_cfg_valid, i_cfg_half,
//        o_cfg_ready, o_cfg_err, o_clk, o_tick, o_busy (all outputs registered).
module clk_div_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = CNT_W,
  parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
  input  logic                 i_clk_FPGA,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_cfg_valid,
  input  logic [CNT_WIDTH-1:0] i_cfg_half,
  output logic                 o_cfg_ready,
  output logic                 o_cfg_err,
  output logic                 o_clk,
  output logic                 o_tick,
  output logic                 o_busy
);

  div_state_t           state;
  div_state_t           state_nxt;
  logic [CNT_WIDTH-1:0] active_half;
  logic [CNT_WIDTH-1:0] pend_half;
  logic                 pend_valid;
  logic                 en;
  logic                 clr;
  logic                 wrap;
  logic                 wrap_rise;
  logic                 fall;
  logic                 apply;
  logic                 accept;
  logic                 accept_zero;
  logic                 accept_ok;

  clk_div_core #(
    .W(CNT_WIDTH)
  ) u_core (
    .clk      (i_clk_FPGA),
    .rst      (i_reset),
    .en       (en),
    .clr      (clr),
    .half     (active_half),
    .o_clk    (o_clk),
    .wrap     (wrap),
    .wrap_rise(wrap_rise)
  );

  // Falling toggle: end of a full period.
  assign fall = wrap && o_clk;

  always_ff @(posedge i_clk_FPGA or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (i_start && !i_stop) state_nxt = RUN;
      end
      RUN: begin
        if (i_stop && !o_clk) begin
          // Low phase: stop at once, no toggle this edge.
          clr       = 1'b1;
          state_nxt = IDLE;
        end else begin
          en = 1'b1;
          // High phase: finish it; if it ends now, go straight to IDLE.
          if (i_stop) state_nxt = fall ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        en = 1'b1;
        if (fall) state_nxt = IDLE;
      end
      default: begin
        clr       = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept      = i_cfg_valid && o_cfg_ready;
  assign accept_zero = accept && (i_cfg_half == '0);
  assign accept_ok   = accept && (i_cfg_half != '0);
  assign apply       = pend_valid && ((state == IDLE) || (en && fall));

  always_ff @(posedge i_clk_FPGA or posedge i_reset) begin
    if (i_reset) begin
      o_tick      <= 1'b0;
      o_busy      <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_cfg_ready <= 1'b1;
      active_half <= CNT_WIDTH'(DEFAULT_HALF);
      pend_half   <= '0;
      pend_valid  <= 1'b0;
    end else begin
      o_tick    <= en && wrap_rise;
      o_busy    <= (state_nxt != IDLE);
      o_cfg_err <= accept_zero;
      if (apply) active_half <= pend_half;
      if (accept_ok) begin
        pend_half  <= i_cfg_half;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
      // Ready reopens one cycle after the pending value is applied.
      if (accept_ok) o_cfg_ready <= 1'b0;
      else           o_cfg_ready <= !pend_valid;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: phase-level reference model plus
// directed literal checks and a randomized run.
module tb_clk_div_ctrl;

  localparam int W  = 32;
  localparam int DH = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_half = '0;
  logic         cfg_ready;
  logic         cfg_err;
  logic         dclk;
  logic         tick;
  logic         busy;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  clk_div_ctrl #(
    .CNT_WIDTH   (W),
    .DEFAULT_HALF(DH)
  ) dut (
    .i_clk_FPGA (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_cfg_valid(cfg_valid),
    .i_cfg_half (cfg_half),
    .o_cfg_ready(cfg_ready),
    .o_cfg_err  (cfg_err),
    .o_clk      (dclk),
    .o_tick     (tick),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 run, 2 drain; left = cycles left in phase.
  int m_mode;
  bit m_lvl;
  int m_left;
  int m_half;
  int m_pend;
  bit m_ready;
  bit m_err;
  bit m_tick;
  bit m_busy;
  bit m_applied;

  task automatic model_reset();
    m_mode = 0; m_lvl = 0; m_left = 0; m_half = DH; m_pend = 0;
    m_ready = 1; m_err = 0; m_tick = 0; m_busy = 0; m_applied = 0;
  endtask

  task automatic model_step();
    bit acc, act, wrp, fal, app;
    int nh;
    acc = cfg_valid && m_ready;
    act = (m_mode == 1 && !(stop && !m_lvl)) || m_mode == 2;
    wrp = act && m_left == 1;
    fal = wrp && m_lvl;
    app = m_pend != 0 && (m_mode == 0 || fal);
    nh  = app ? m_pend : m_half;
    m_tick = wrp && !m_lvl;
    m_err  = acc && cfg_half == 0;
    if (acc && cfg_half != 0) m_ready = 0;
    else if (m_applied)       m_ready = 1;
    m_applied = app;
    if (app) m_pend = 0;
    if (acc && cfg_half != 0) m_pend = int'(cfg_half);
    m_half = nh;
    case (m_mode)
      0: if (start && !stop) begin
        m_mode = 1; m_left = nh; m_lvl = 0;
      end
      1: if (stop && !m_lvl) m_mode = 0;
         else begin
           if (wrp) begin m_lvl = !m_lvl; m_left = nh; end
           else m_left--;
           if (stop) m_mode = fal ? 0 : 2;
         end
      default: begin
        if (wrp) begin m_lvl = !m_lvl; m_left = nh; end
        else m_left--;
        if (fal) m_mode = 0;
      end
    endcase
    m_busy = m_mode != 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("clk",   dclk,      m_lvl);
      check("tick",  tick,      m_tick);
      check("busy",  busy,      m_busy);
      check("ready", cfg_ready, m_ready);
      check("err",   cfg_err,   m_err);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(int h);
    cfg_valid = 1'b1;
    cfg_half  = W'(h);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_ready && n < 200) begin cyc(1); n++; end
    if (n >= 200) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_tick();
    int n = 0;
    cyc(1);
    while (!tick && n < 200) begin cyc(1); n++; end
    if (n >= 200) check("wait_tick_timeout", 0, 1);
  endtask

  task automatic cnt_rise(output int m);
    m = 0;
    while (!dclk && m < 200) begin cyc(1); m++; end
  endtask

  task automatic cnt_level(input logic lvl, output int m);
    m = 0;
    while (dclk == lvl && m < 200) begin m++; cyc(1); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m;
    cyc(2);
    check("rst_clk", dclk, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_tick", tick, 0);
    check("rst_err", cfg_err, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Idle configuration: ready low after j and j+1, high after j+2.
    offer(3);
    check("idle_ready_j", cfg_ready, 0);
    cyc(1);
    check("idle_ready_j1", cfg_ready, 0);
    cyc(1);
    check("idle_ready_j2", cfg_ready, 1);

    // Start with H=3.
    start = 1'b1; cyc(1); start = 1'b0;
    cnt_rise(m);
    check("first_rise_h3", m, 3);
    check("first_tick", tick, 1);
    cnt_level(1'b1, m);
    check("high_h3", m, 3);
    cnt_level(1'b0, m);
    check("low_h3", m, 3);

    // Reconfigure to 5 during a high phase.
    offer(5);
    check("reconf_ready_drop", cfg_ready, 0);
    cnt_level(1'b1, m);
    check("reconf_high_left", m, 2);
    cnt_level(1'b0, m);
    check("reconf_low_h5", m, 5);
    check("reconf_ready_back", cfg_ready, 1);
    cnt_level(1'b1, m);
    check("reconf_high_h5", m, 5);

    // Zero configuration is rejected.
    offer(0);
    check("zero_err", cfg_err, 1);
    check("zero_ready", cfg_ready, 1);
    cyc(1);
    check("zero_err_pulse", cfg_err, 0);
    wait_tick();
    cnt_level(1'b1, m);
    check("zero_period_kept", m, 5);

    // Stop one cycle into a high phase with H=4.
    offer(4);
    wait_ready();
    wait_tick();
    stop = 1'b1; cyc(1); stop = 1'b0;
    check("drain_busy", busy, 1);
    cnt_level(1'b1, m);
    check("drain_high_left", m, 3);
    check("drain_busy_drop", busy, 0);

    // Stop during the low phase.
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    check("low_run_busy", busy, 1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    check("low_stop_busy", busy, 0);
    check("low_stop_clk", dclk, 0);
    cyc(5);
    check("low_stop_clk_hold", dclk, 0);

    // Start and stop together.
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    cyc(3);
    check("startstop_busy2", busy, 0);

    // Reset during DRAIN with a pending configuration.
    start = 1'b1; cyc(1); start = 1'b0;
    wait_tick();
    stop = 1'b1; cyc(1); stop = 1'b0;
    offer(2);
    check("drain_pend_ready", cfg_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_clk", dclk, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", cfg_ready, 1);
    check("async_rst_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cnt_rise(m);
    check("default_half_rise", m, DH);

    // Randomized run against the model.
    repeat (3000) begin
      @(negedge clk);
      start     = ($urandom % 10) == 0;
      stop      = ($urandom % 25) == 0;
      cfg_valid = ($urandom % 6) == 0;
      cfg_half  = W'($urandom_range(0, 6));
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the programmable clock divider. Sequences start/stop of the divided clock, accepts new half-period settings over a valid/ready handshake, and applies them only at period boundaries so that `o_clk` never glitches and always keeps a 50 % duty cycle. It sits between the board control logic (switches or a register interface) and every consumer of the slow clock or its tick.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of the half-period counter and of the configuration word.
- `DEFAULT_HALF`, 5000: half-period, in input clock cycles, loaded at reset.

Ports:
- `i_clk_FPGA`  in  1: the single clock; all logic is on its rising edge.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_start`  in  1: level-sampled start request.
- `i_stop`  in  1: level-sampled stop request.
- `i_cfg_valid`  in  1: a new half-period is offered.
- `i_cfg_half`  in  CNT_WIDTH: the offered half-period, in input cycles.
- `o_cfg_ready`  out  1: the controller can accept a configuration.
- `o_cfg_err`  out  1: one-cycle pulse when a configuration of 0 is rejected.
- `o_clk`  out  1: divided clock.
- `o_tick`  out  1: one-cycle pulse in the cycle where `o_clk` rises.
- `o_busy`  out  1: high in RUN and DRAIN.

## Operation
- Reset values:
  - State IDLE.
  - `o_clk`=0, `o_tick`=0, `o_busy`=0, `o_cfg_err`=0, `o_cfg_ready`=1.
  - Counter 0, active half = `DEFAULT_HALF`, no pending configuration.
- FSM states are IDLE, RUN and DRAIN.
  - **IDLE to RUN:** `i_start`=1 and `i_stop`=0. The counter is cleared.
  - **RUN to IDLE:** `i_stop`=1 while `o_clk`=0. The stop takes effect immediately.
  - **RUN to DRAIN:** `i_stop`=1 while `o_clk`=1.
  - **DRAIN to IDLE:** at the falling toggle of `o_clk`, so the high phase always completes.
  - `i_start` has no effect in RUN or DRAIN.
  - If `i_start` and `i_stop` are asserted in the same cycle, stop wins.
- Counting, in RUN and DRAIN:
  - Each cycle, if counter == active_half−1, the counter goes to 0 and `o_clk` toggles. Otherwise the counter increments.
  - In IDLE, the counter holds 0 and `o_clk` holds 0.
- Configuration handshake:
  - A transfer occurs when `i_cfg_valid` and `o_cfg_ready` are both 1.
  - A value of 0 is not stored. It produces an `o_cfg_err` pulse in the next cycle, and `o_cfg_ready` stays 1.
  - A nonzero value is stored in the pending register, and `o_cfg_ready` goes to 0.
- Applying a pending configuration:
  - In IDLE, it is applied on the next cycle.
  - In RUN or DRAIN, it is applied at the next falling toggle of `o_clk` (end of a full period). The new half-period governs the following low phase.
  - `o_cfg_ready` returns to 1 in the cycle after the apply.
- Half-period value 1 gives `o_clk` = f_in/2. All arithmetic is unsigned, `CNT_WIDTH` bits, with no wrap, because active_half is at least 1.
- Reset mid-operation returns every register immediately to its reset value, and any pending configuration is discarded.

## Timing
- `i_start` sampled at edge k: `o_clk` rises at edge k+H, where H is the active half. `o_tick`=1 for exactly that cycle.
- Steady state: `o_clk` has period 2H cycles, high for H and low for H.
- Configuration accepted at edge j in IDLE: active half updated at edge j+1, `o_cfg_ready`=1 after edge j+2.
- Stop with `o_clk`=0: `o_busy`=0 after the next edge, and `o_clk` stays 0.
- Stop with `o_clk`=1: `o_busy` drops in the same edge at which `o_clk` falls.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- The package `clk_pkg` holds:
  - `counter_t` (logic [CNT_WIDTH-1:0]).
  - The state enum `div_state_t` {IDLE, RUN, DRAIN}.
  - The default `DEFAULT_HALF`.
- One sub-module, `clk_div_core`, holds the counter and toggle logic. Its inputs are enable, clear and active_half; its outputs are `o_clk` and a wrap pulse tagged rise/fall.
- `clk_div_ctrl` holds the FSM, the pending/active configuration registers and the handshake.

## Test plan
- **Reset:** assert `i_reset` asynchronously, mid-cycle. All outputs take their reset values at once, and `o_cfg_ready`=1.
- **Start:** configure H=3, then pulse `i_start`. First rise is 3 cycles after start; then period 6, duty 3/3, and one `o_tick` per rise.
- **Mid-run reconfiguration:** while running with H=3, offer H=5 during a high phase. `o_cfg_ready` drops; the current period finishes with 3/3; the next low phase is 5 cycles; `o_cfg_ready` is back after the apply.
- **Invalid configuration:** offer H=0. Expect a one-cycle `o_cfg_err`, `o_cfg_ready` stays 1, and the running period is unchanged.
- **Stop:**
  - Stop while `o_clk`=1 with H=4 and 1 cycle into the high phase: `o_clk` stays high 3 more cycles, then falls, and `o_busy`=0 at the same edge.
  - Stop while `o_clk`=0: immediate return to IDLE.
- **Simultaneous events:**
  - `i_start` and `i_stop` together in IDLE: the controller stays in IDLE.
  - Reset asserted during DRAIN with a configuration pending: the controller returns to IDLE with H=`DEFAULT_HALF` and the pending configuration discarded.
